// File: rtl/wb_regfile_pkg.sv
// Shared constants for the integer register file: datapath width, special
// register indices, and the reset-value selector used by the array.
package wb_regfile_pkg;

  localparam int MAX_BIT_POS = 31;
  localparam int NUM_REGS    = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_SP   = 5'd2;
  localparam logic [4:0] REG_GP   = 5'd3;

  // Reset contents of architectural register idx (sp/gp are configurable).
  function automatic logic [MAX_BIT_POS:0] reset_value(
    input logic [4:0]           idx,
    input logic [MAX_BIT_POS:0] sp_val,
    input logic [MAX_BIT_POS:0] gp_val
  );
    logic [MAX_BIT_POS:0] v;
    v = '0;
    if (idx == REG_SP) v = sp_val;
    if (idx == REG_GP) v = gp_val;
    return v;
  endfunction

endpackage

// File: rtl/wb_regfile_scoreboard.sv
// Busy-bit scoreboard for x1..x31. A set (new producer issued) beats a
// same-cycle clear (writeback); flush beats everything. x0 is never busy.
module regfile_scoreboard
  import wb_regfile_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        set_en,
  input  logic [4:0]  set_idx,
  input  logic        clr_en,
  input  logic [4:0]  clr_idx,
  input  logic        flush,
  output logic [31:0] busy
);

  logic [31:1] busy_q;

  // Busy bit update: flush, then clear, then set so the set overrides a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else if (flush) begin
      busy_q <= '0;
    end else begin
      if (clr_en && clr_idx != REG_ZERO) busy_q[clr_idx] <= 1'b0;
      if (set_en && set_idx != REG_ZERO) busy_q[set_idx] <= 1'b1;
    end
  end

  assign busy = {busy_q, 1'b0};

endmodule

// File: rtl/wb_regfile.sv
// Integer register file x1..x31 with writeback port, two combinational read
// ports and a RAW scoreboard. Define REGFILE_BYPASS_EN to forward same-cycle
// writeback data to the read ports and mask their busy flags.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter logic [MAX_BIT_POS:0] SP_RESET = 32'h0000_0000,
  parameter logic [MAX_BIT_POS:0] GP_RESET = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_en,
  input  logic [4:0]             wb_rd,
  input  logic [MAX_BIT_POS:0]   wb_data,
  input  logic [4:0]             rs1_addr,
  input  logic [4:0]             rs2_addr,
  output logic [MAX_BIT_POS:0]   rs1_data,
  output logic [MAX_BIT_POS:0]   rs2_data,
  output logic                   rs1_busy,
  output logic                   rs2_busy,
  input  logic                   issue_valid,
  input  logic [4:0]             issue_rd,
  input  logic                   issue_wr,
  input  logic                   flush
);

  logic [MAX_BIT_POS:0] regs [1:NUM_REGS-1];
  logic [31:0]          busy;
  logic                 wb_write;

  assign wb_write = wb_en && (wb_rd != REG_ZERO);

  // Architectural register array; x0 has no storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 1; i < NUM_REGS; i++)
        regs[i] <= reset_value(5'(i), SP_RESET, GP_RESET);
    end else if (wb_write) begin
      regs[wb_rd] <= wb_data;
    end
  end

  regfile_scoreboard u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_en  (issue_valid && issue_wr),
    .set_idx (issue_rd),
    .clr_en  (wb_write),
    .clr_idx (wb_rd),
    .flush   (flush),
    .busy    (busy)
  );

`ifdef REGFILE_BYPASS_EN
  // Reset gates the bypass so outputs show reset contents while rst is high.
  logic byp_live;
  assign byp_live = wb_write && !rst;
`endif

  // Read ports: array lookup with x0 hardwired to zero, optional forwarding.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    rs1_busy = busy[rs1_addr];
    rs2_busy = busy[rs2_addr];
    if (rs1_addr != REG_ZERO) rs1_data = regs[rs1_addr];
    if (rs2_addr != REG_ZERO) rs2_data = regs[rs2_addr];
`ifdef REGFILE_BYPASS_EN
    if (byp_live && wb_rd == rs1_addr) begin
      rs1_data = wb_data;
      rs1_busy = 1'b0;
    end
    if (byp_live && wb_rd == rs2_addr) begin
      rs2_data = wb_data;
      rs2_busy = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile (SP_RESET overridden).
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        rs1_busy, rs2_busy;
  logic        issue_valid, issue_wr, flush;
  logic [4:0]  issue_rd;

  int checks = 0;
  int passed = 0;

  wb_regfile #(.SP_RESET(32'h2000_1000), .GP_RESET(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_wr(issue_wr),
    .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic idle();
    wb_en = 0; wb_rd = 0; wb_data = '0;
    issue_valid = 0; issue_wr = 0; issue_rd = 0; flush = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    rs1_addr = 5'd2; rs2_addr = 5'd5;
    wb_en = 1; wb_rd = 5'd5; wb_data = 32'hDEAD_0005;
    issue_valid = 1; issue_wr = 1; issue_rd = 5'd5;
    @(negedge clk); #1;
    checks++; if (rs1_data !== 32'h2000_1000) $display("FAIL reset_sp: got %h want %h", rs1_data, 32'h2000_1000); else passed++;
    checks++; if (rs2_data !== 32'h0) $display("FAIL reset_x5: got %h want %h", rs2_data, 32'h0); else passed++;
    checks++; if ({rs1_busy, rs2_busy} !== 2'b00) $display("FAIL reset_busy: got %b want %b", {rs1_busy, rs2_busy}, 2'b00); else passed++;
    @(negedge clk);
    rst = 0; idle();
    #1;
    checks++; if (rs2_data !== 32'h0) $display("FAIL reset_write_ignored: got %h want %h", rs2_data, 32'h0); else passed++;
    checks++; if (rs2_busy !== 1'b0) $display("FAIL reset_issue_ignored: got %b want %b", rs2_busy, 1'b0); else passed++;
  endtask

  task automatic test_x0();
    @(negedge clk); idle();
    wb_en = 1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
    issue_valid = 1; issue_wr = 1; issue_rd = 5'd0;
    rs1_addr = 5'd0; rs2_addr = 5'd3;
    #1;
    checks++; if (rs1_data !== 32'h0) $display("FAIL x0_same_cycle: got %h want %h", rs1_data, 32'h0); else passed++;
    @(negedge clk); idle(); #1;
    checks++; if (rs1_data !== 32'h0) $display("FAIL x0_read: got %h want %h", rs1_data, 32'h0); else passed++;
    checks++; if (rs1_busy !== 1'b0) $display("FAIL x0_busy: got %b want %b", rs1_busy, 1'b0); else passed++;
    checks++; if (rs2_data !== 32'h0) $display("FAIL gp_reset: got %h want %h", rs2_data, 32'h0); else passed++;
  endtask

  task automatic test_raw_hazard();
    // cycle 0: issue x7
    @(negedge clk); idle();
    rs1_addr = 5'd7; rs2_addr = 5'd7;
    issue_valid = 1; issue_wr = 1; issue_rd = 5'd7;
    #1;
    checks++; if (rs1_busy !== 1'b0) $display("FAIL raw_c0_busy: got %b want %b", rs1_busy, 1'b0); else passed++;
    // cycles 1,2
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk); idle(); #1;
      checks++; if (rs1_busy !== 1'b1) $display("FAIL raw_c%0d_busy: got %b want %b", c, rs1_busy, 1'b1); else passed++;
    end
    // cycle 3: writeback
    @(negedge clk); idle();
    wb_en = 1; wb_rd = 5'd7; wb_data = 32'h1234_5678;
    #1;
`ifdef REGFILE_BYPASS_EN
    checks++; if (rs1_data !== 32'h1234_5678) $display("FAIL raw_c3_data: got %h want %h", rs1_data, 32'h1234_5678); else passed++;
    checks++; if (rs1_busy !== 1'b0) $display("FAIL raw_c3_busy: got %b want %b", rs1_busy, 1'b0); else passed++;
`else
    checks++; if (rs1_data !== 32'h0) $display("FAIL raw_c3_data: got %h want %h", rs1_data, 32'h0); else passed++;
    checks++; if (rs1_busy !== 1'b1) $display("FAIL raw_c3_busy: got %b want %b", rs1_busy, 1'b1); else passed++;
`endif
    // cycle 4
    @(negedge clk); idle(); #1;
    checks++; if (rs1_data !== 32'h1234_5678) $display("FAIL raw_c4_data: got %h want %h", rs1_data, 32'h1234_5678); else passed++;
    checks++; if (rs1_busy !== 1'b0) $display("FAIL raw_c4_busy: got %b want %b", rs1_busy, 1'b0); else passed++;
  endtask

  task automatic test_set_clear_collision();
    @(negedge clk); idle();
    issue_valid = 1; issue_wr = 1; issue_rd = 5'd9;
    wb_en = 1; wb_rd = 5'd9; wb_data = 32'hCAFE_0009;
    @(negedge clk); idle();
    rs1_addr = 5'd9; rs2_addr = 5'd9;
    #1;
    checks++; if (rs1_busy !== 1'b1) $display("FAIL collide_busy: got %b want %b", rs1_busy, 1'b1); else passed++;
    checks++; if (rs2_data !== 32'hCAFE_0009) $display("FAIL collide_data: got %h want %h", rs2_data, 32'hCAFE_0009); else passed++;
    // issue without write flag does not mark busy
    issue_valid = 1; issue_wr = 0; issue_rd = 5'd12;
    @(negedge clk); idle();
    rs1_addr = 5'd12; #1;
    checks++; if (rs1_busy !== 1'b0) $display("FAIL issue_nowr: got %b want %b", rs1_busy, 1'b0); else passed++;
  endtask

  task automatic test_flush();
    for (int r = 4; r <= 6; r++) begin
      @(negedge clk); idle();
      issue_valid = 1; issue_wr = 1; issue_rd = 5'(r);
    end
    @(negedge clk); idle();
    rs1_addr = 5'd4; rs2_addr = 5'd6; #1;
    checks++; if ({rs1_busy, rs2_busy} !== 2'b11) $display("FAIL preflush_busy: got %b want %b", {rs1_busy, rs2_busy}, 2'b11); else passed++;
    flush = 1; issue_valid = 1; issue_wr = 1; issue_rd = 5'd8;
    @(negedge clk); idle();
    for (int r = 4; r <= 9; r++) begin
      rs1_addr = 5'(r); #1;
      checks++; if (rs1_busy !== 1'b0) $display("FAIL flush_x%0d: got %b want %b", r, rs1_busy, 1'b0); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); idle();
    wb_en = 1; wb_rd = 5'd11; wb_data = 32'h0000_0001;
    @(negedge clk);
    wb_data = 32'h0000_0002;
    rs1_addr = 5'd11; rs2_addr = 5'd11; #1;
`ifdef REGFILE_BYPASS_EN
    checks++; if (rs1_data !== 32'h0000_0002) $display("FAIL b2b_mid: got %h want %h", rs1_data, 32'h0000_0002); else passed++;
`else
    checks++; if (rs1_data !== 32'h0000_0001) $display("FAIL b2b_mid: got %h want %h", rs1_data, 32'h0000_0001); else passed++;
`endif
    @(negedge clk); idle(); #1;
    checks++; if (rs2_data !== 32'h0000_0002) $display("FAIL b2b_final: got %h want %h", rs2_data, 32'h0000_0002); else passed++;
  endtask

  task automatic test_async_reset();
    @(negedge clk); idle();
    wb_en = 1; wb_rd = 5'd10; wb_data = 32'hA5A5_A5A5;
    @(negedge clk); idle();
    issue_valid = 1; issue_wr = 1; issue_rd = 5'd10;
    @(negedge clk); idle();
    rs1_addr = 5'd10; rs2_addr = 5'd2; #1;
    checks++; if (rs1_data !== 32'hA5A5_A5A5) $display("FAIL pre_rst_data: got %h want %h", rs1_data, 32'hA5A5_A5A5); else passed++;
    checks++; if (rs1_busy !== 1'b1) $display("FAIL pre_rst_busy: got %b want %b", rs1_busy, 1'b1); else passed++;
    #1 rst = 1;
    #1;
    checks++; if (rs1_data !== 32'h0) $display("FAIL async_rst_data: got %h want %h", rs1_data, 32'h0); else passed++;
    checks++; if (rs1_busy !== 1'b0) $display("FAIL async_rst_busy: got %b want %b", rs1_busy, 1'b0); else passed++;
    checks++; if (rs2_data !== 32'h2000_1000) $display("FAIL async_rst_sp: got %h want %h", rs2_data, 32'h2000_1000); else passed++;
    @(negedge clk); rst = 0;
    rs1_addr = 5'd7; #1;
    checks++; if (rs1_data !== 32'h0) $display("FAIL rst_lost_x7: got %h want %h", rs1_data, 32'h0); else passed++;
    // first edge after release accepts a write
    wb_en = 1; wb_rd = 5'd13; wb_data = 32'h0BAD_F00D;
    @(negedge clk); idle();
    rs1_addr = 5'd13; #1;
    checks++; if (rs1_data !== 32'h0BAD_F00D) $display("FAIL post_rst_write: got %h want %h", rs1_data, 32'h0BAD_F00D); else passed++;
  endtask

  initial begin
    rs1_addr = 0; rs2_addr = 0;
    test_reset();
    test_x0();
    test_raw_hazard();
    test_set_clear_collision();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
